// File: rtl/sii_ncu_xfer_chk_if.sv
// SII->NCU inbound bus bundle: per-channel request/grant pulses, data and lane parity.
// master : drives the bus (SIU side / stimulus)
// slave  : observes the bus (checker)
interface sii_ncu_xfer_chk_if #(
  parameter int unsigned N_CH = 1,
  parameter int unsigned DW   = 32
) ();
  logic [N_CH-1:0]         sii_ncu_req;
  logic [N_CH-1:0]         ncu_sii_gnt;
  logic [N_CH*DW-1:0]      sii_ncu_data;
  logic [N_CH*DW/16-1:0]   sii_ncu_dparity;

  modport master (
    output sii_ncu_req, ncu_sii_gnt, sii_ncu_data, sii_ncu_dparity
  );
  modport slave (
    input sii_ncu_req, ncu_sii_gnt, sii_ncu_data, sii_ncu_dparity
  );
endinterface

// File: rtl/sii_ncu_xfer_chk.sv
// Passive multi-channel checker for the SIU->NCU inbound path (Mondo / PIO completions).
// Per channel: tracks outstanding requests vs grants, frames each granted packet
// (1 header beat + PAY_BEATS payload beats), checks payload lane parity, and flags
// spurious grants, request overflow and grant timeout.
// Ports:
//   iol2clk, io_rst  clock, synchronous active-high reset
//   enable_i         checker enable; low drops in-flight packets and clears tracking
//   err_clr_i        clears sticky error bits
//   bus              observed SII->NCU bundle (slave modport)
//   chk_busy_o       channel framing a packet (HDR or PAY)
//   chk_pkt_done_o   one-cycle pulse per completed packet
//   chk_hdr_o        header of last completed packet, DW per channel
//   chk_pkt_cnt_o    wrapping completed-packet count, CNTW per channel
//   chk_err_o        sticky errors per channel: [0] parity [1] spurious gnt
//                    [2] timeout [3] request overflow
module sii_ncu_xfer_chk #(
  parameter int unsigned N_CH      = 1,
  parameter int unsigned DW        = 32,
  parameter int unsigned PAY_BEATS = 4,
  parameter int unsigned MAX_OUT   = 2,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNTW      = 16,
  parameter int unsigned PAR_ODD   = 0
) (
  input  logic                   iol2clk,
  input  logic                   io_rst,
  input  logic                   enable_i,
  input  logic                   err_clr_i,
  sii_ncu_xfer_chk_if.slave      bus,
  output logic [N_CH-1:0]        chk_busy_o,
  output logic [N_CH-1:0]        chk_pkt_done_o,
  output logic [N_CH*DW-1:0]     chk_hdr_o,
  output logic [N_CH*CNTW-1:0]   chk_pkt_cnt_o,
  output logic [N_CH*4-1:0]      chk_err_o
);

  localparam int unsigned NL       = DW / 16;
  localparam logic [2:0]  MaxOut   = 3'(MAX_OUT);
  localparam logic [15:0] TmrLast  = 16'(TIMEOUT - 1);
  localparam logic [15:0] TmrSat   = 16'(TIMEOUT);
  localparam logic [3:0]  LastBeat = 4'(PAY_BEATS - 1);
  localparam logic        ParExp   = 1'(PAR_ODD);

  typedef enum logic [1:0] {StIdle, StHdr, StPay} state_e;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_e          state_q, state_d;
    logic [3:0]      beat_q, beat_d;
    logic [2:0]      out_q, out_d;
    logic [15:0]     tmr_q, tmr_d;
    logic [DW-1:0]   shd_q, shd_d;
    logic [DW-1:0]   hdr_q, hdr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [3:0]      err_q, err_d, err_new;
    logic            done_q, done_d;
    logic            req, gnt, spur, acc;
    logic [DW-1:0]   data;
    logic [NL-1:0]   par, lane_bad;

    assign req  = bus.sii_ncu_req[c];
    assign gnt  = bus.ncu_sii_gnt[c];
    assign data = bus.sii_ncu_data[c*DW +: DW];
    assign par  = bus.sii_ncu_dparity[c*NL +: NL];

    // A grant with req in the same cycle is valid even at zero outstanding.
    assign spur = gnt && ((state_q != StIdle) || ((out_q == 3'd0) && !req));
    assign acc  = gnt && !spur;

    always_comb begin
      lane_bad = '0;
      for (int i = 0; i < NL; i++) begin
        lane_bad[i] = (^{data[16*i +: 16], par[i]}) != ParExp;
      end
    end

    always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      out_d      = out_q;
      tmr_d      = tmr_q;
      shd_d      = shd_q;
      hdr_d      = hdr_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      err_new    = '0;
      err_new[1] = spur;

      if (req && !acc) begin
        if (out_q == MaxOut) err_new[3] = 1'b1;
        else                 out_d = out_q + 3'd1;
      end else if (!req && acc) begin
        out_d = out_q - 3'd1;
      end

      // Timer saturates at TIMEOUT so the error fires once per wait episode.
      if (acc || (out_q == 3'd0)) begin
        tmr_d = '0;
      end else if ((state_q == StIdle) && (tmr_q != TmrSat)) begin
        tmr_d = tmr_q + 16'd1;
        if (tmr_q == TmrLast) err_new[2] = 1'b1;
      end

      case (state_q)
        StIdle: if (acc) state_d = StHdr;
        StHdr: begin
          shd_d   = data;
          beat_d  = '0;
          state_d = StPay;
        end
        StPay: begin
          err_new[0] = |lane_bad;
          beat_d     = beat_q + 4'd1;
          if (beat_q == LastBeat) begin
            state_d = StIdle;
            done_d  = 1'b1;
            hdr_d   = shd_q;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase

      // New errors win over a simultaneous clear.
      err_d = (err_clr_i ? 4'b0 : err_q) | err_new;

      if (!enable_i) begin
        state_d = StIdle;
        beat_d  = '0;
        out_d   = '0;
        tmr_d   = '0;
        shd_d   = shd_q;
        hdr_d   = hdr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
      end
    end

    always_ff @(posedge iol2clk) begin
      if (io_rst) begin
        state_q <= StIdle;
        beat_q  <= '0;
        out_q   <= '0;
        tmr_q   <= '0;
        shd_q   <= '0;
        hdr_q   <= '0;
        cnt_q   <= '0;
        err_q   <= '0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        beat_q  <= beat_d;
        out_q   <= out_d;
        tmr_q   <= tmr_d;
        shd_q   <= shd_d;
        hdr_q   <= hdr_d;
        cnt_q   <= cnt_d;
        err_q   <= err_d;
        done_q  <= done_d;
      end
    end

    assign chk_busy_o[c]                = (state_q != StIdle);
    assign chk_pkt_done_o[c]            = done_q;
    assign chk_hdr_o[c*DW +: DW]        = hdr_q;
    assign chk_pkt_cnt_o[c*CNTW +: CNTW] = cnt_q;
    assign chk_err_o[c*4 +: 4]          = err_q;
  end

endmodule

// File: tb/tb_sii_ncu_xfer_chk.sv
// Directed bench for sii_ncu_xfer_chk: a default single-channel instance and a
// two-channel 64-bit instance with two payload beats.
module tb_sii_ncu_xfer_chk;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en0, en1, clr0, clr1;

  sii_ncu_xfer_chk_if #(.N_CH(1), .DW(32)) bus0 ();
  sii_ncu_xfer_chk_if #(.N_CH(2), .DW(64)) bus1 ();

  logic        busy0, done0;
  logic [31:0] hdr0;
  logic [15:0] cnt0;
  logic [3:0]  err0;

  logic [1:0]   busy1, done1;
  logic [127:0] hdr1;
  logic [31:0]  cnt1;
  logic [7:0]   err1;

  sii_ncu_xfer_chk #(
    .N_CH(1), .DW(32), .PAY_BEATS(4), .MAX_OUT(2), .TIMEOUT(16), .CNTW(16), .PAR_ODD(0)
  ) dut0 (
    .iol2clk        (clk),
    .io_rst         (rst),
    .enable_i       (en0),
    .err_clr_i      (clr0),
    .bus            (bus0),
    .chk_busy_o     (busy0),
    .chk_pkt_done_o (done0),
    .chk_hdr_o      (hdr0),
    .chk_pkt_cnt_o  (cnt0),
    .chk_err_o      (err0)
  );

  sii_ncu_xfer_chk #(
    .N_CH(2), .DW(64), .PAY_BEATS(2), .MAX_OUT(2), .TIMEOUT(16), .CNTW(16), .PAR_ODD(0)
  ) dut1 (
    .iol2clk        (clk),
    .io_rst         (rst),
    .enable_i       (en1),
    .err_clr_i      (clr1),
    .bus            (bus1),
    .chk_busy_o     (busy1),
    .chk_pkt_done_o (done1),
    .chk_hdr_o      (hdr1),
    .chk_pkt_cnt_o  (cnt1),
    .chk_err_o      (err1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [1:0] par32(input logic [31:0] d);
    par32 = {^d[31:16], ^d[15:0]};
  endfunction

  function automatic logic [3:0] par64(input logic [63:0] d);
    par64 = {^d[63:48], ^d[47:32], ^d[31:16], ^d[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc0(input logic r, input logic g, input logic [31:0] d, input logic flip);
    logic [1:0] p;
    p = par32(d);
    p[0] = p[0] ^ flip;
    bus0.sii_ncu_req     = r;
    bus0.ncu_sii_gnt     = g;
    bus0.sii_ncu_data    = d;
    bus0.sii_ncu_dparity = p;
    tick();
  endtask

  task automatic cyc1(input logic [1:0] r, input logic [1:0] g, input logic [63:0] d0,
                      input logic [63:0] d1);
    bus1.sii_ncu_req     = r;
    bus1.ncu_sii_gnt     = g;
    bus1.sii_ncu_data    = {d1, d0};
    bus1.sii_ncu_dparity = {par64(d1), par64(d0)};
    tick();
  endtask

  task automatic do_reset();
    bus0.sii_ncu_req = '0; bus0.ncu_sii_gnt = '0;
    bus0.sii_ncu_data = '0; bus0.sii_ncu_dparity = '0;
    bus1.sii_ncu_req = '0; bus1.ncu_sii_gnt = '0;
    bus1.sii_ncu_data = '0; bus1.sii_ncu_dparity = '0;
    clr0 = 1'b0; clr1 = 1'b0; en0 = 1'b1; en1 = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Grant, header, then four payload beats 0x11111111 .. 0x44444444.
  task automatic send_pkt0(input logic [31:0] h, input int bad_beat, input int spur_beat,
                           input logic req_on_gnt);
    logic [31:0] d;
    cyc0(req_on_gnt, 1'b1, 32'h0, 1'b0);
    cyc0(1'b0, 1'b0, h, 1'b0);
    for (int b = 0; b < 4; b++) begin
      d = 32'h11111111 * 32'(b + 1);
      cyc0(1'b0, (b == spur_beat), d, (b == bad_beat));
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_busy0 got=%b exp=0", busy0); end
    n_chk++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL rst_done0 got=%b exp=0", done0); end
    n_chk++; if (hdr0 !== 32'h0) begin n_fail++; $display("FAIL rst_hdr0 got=%h exp=0", hdr0); end
    n_chk++; if (cnt0 !== 16'h0) begin n_fail++; $display("FAIL rst_cnt0 got=%h exp=0", cnt0); end
    n_chk++; if (err0 !== 4'h0) begin n_fail++; $display("FAIL rst_err0 got=%b exp=0", err0); end
    n_chk++;
    if ({busy1, done1, hdr1, cnt1, err1} !== '0) begin
      n_fail++; $display("FAIL rst_dut1 got=%h exp=0", {busy1, done1, hdr1, cnt1, err1});
    end
  endtask

  task automatic test_basic();
    do_reset();
    cyc0(1'b1, 1'b0, 32'h0, 1'b0);        // cycle 0: req
    cyc0(1'b0, 1'b0, 32'h0, 1'b0);
    cyc0(1'b0, 1'b0, 32'h0, 1'b0);
    cyc0(1'b0, 1'b1, 32'h0, 1'b0);        // cycle 3: grant
    n_chk++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", busy0); end
    cyc0(1'b0, 1'b0, 32'hA5A50001, 1'b0);
    cyc0(1'b0, 1'b0, 32'h11111111, 1'b0);
    cyc0(1'b0, 1'b0, 32'h22222222, 1'b0);
    cyc0(1'b0, 1'b0, 32'h33333333, 1'b0);
    n_chk++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL basic_early_done got=%b exp=0", done0); end
    cyc0(1'b0, 1'b0, 32'h44444444, 1'b0);
    n_chk++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL basic_done got=%b exp=1", done0); end
    n_chk++; if (hdr0 !== 32'hA5A50001) begin n_fail++; $display("FAIL basic_hdr got=%h exp=a5a50001", hdr0); end
    n_chk++; if (cnt0 !== 16'd1) begin n_fail++; $display("FAIL basic_cnt got=%0d exp=1", cnt0); end
    n_chk++; if (err0 !== 4'h0) begin n_fail++; $display("FAIL basic_err got=%b exp=0000", err0); end
    cyc0(1'b0, 1'b0, 32'h0, 1'b0);
    n_chk++;
    if ({done0, busy0} !== 2'b00) begin
      n_fail++; $display("FAIL basic_after got=%b exp=00", {done0, busy0});
    end
  endtask

  task automatic test_parity();
    do_reset();
    cyc0(1'b1, 1'b0, 32'h0, 1'b0);
    cyc0(1'b0, 1'b1, 32'h0, 1'b0);
    cyc0(1'b0, 1'b0, 32'hA5A50001, 1'b0);
    cyc0(1'b0, 1'b0, 32'h11111111, 1'b0);
    cyc0(1'b0, 1'b0, 32'h22222222, 1'b0);
    n_chk++; if (err0 !== 4'h0) begin n_fail++; $display("FAIL par_pre got=%b exp=0000", err0); end
    cyc0(1'b0, 1'b0, 32'h33333333, 1'b1);  // beat 3 with lane 0 parity flipped
    n_chk++; if (err0 !== 4'b0001) begin n_fail++; $display("FAIL par_err got=%b exp=0001", err0); end
    cyc0(1'b0, 1'b0, 32'h44444444, 1'b0);
    n_chk++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL par_done got=%b exp=1", done0); end
    n_chk++; if (cnt0 !== 16'd1) begin n_fail++; $display("FAIL par_cnt got=%0d exp=1", cnt0); end
    clr0 = 1'b1;
    cyc0(1'b0, 1'b0, 32'h0, 1'b0);
    clr0 = 1'b0;
    n_chk++; if (err0 !== 4'h0) begin n_fail++; $display("FAIL par_clr got=%b exp=0000", err0); end
  endtask

  task automatic test_spurious();
    do_reset();
    cyc0(1'b0, 1'b1, 32'h0, 1'b0);
    n_chk++; if (err0 !== 4'b0010) begin n_fail++; $display("FAIL spur_idle_err got=%b exp=0010", err0); end
    cyc0(1'b0, 1'b0, 32'h0, 1'b0);
    n_chk++;
    if ({busy0, cnt0} !== 17'h0) begin
      n_fail++; $display("FAIL spur_idle_state got=%b/%0d exp=0/0", busy0, cnt0);
    end
    clr0 = 1'b1;
    cyc0(1'b1, 1'b0, 32'h0, 1'b0);        // req alongside the clear
    clr0 = 1'b0;
    n_chk++; if (err0 !== 4'h0) begin n_fail++; $display("FAIL spur_clr got=%b exp=0000", err0); end
    send_pkt0(32'hBEEF0002, -1, 1, 1'b0);  // extra grant on payload beat 2
    n_chk++; if (err0 !== 4'b0010) begin n_fail++; $display("FAIL spur_pay_err got=%b exp=0010", err0); end
    n_chk++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL spur_pay_done got=%b exp=1", done0); end
    n_chk++; if (cnt0 !== 16'd1) begin n_fail++; $display("FAIL spur_pay_cnt got=%0d exp=1", cnt0); end
    n_chk++; if (hdr0 !== 32'hBEEF0002) begin n_fail++; $display("FAIL spur_pay_hdr got=%h exp=beef0002", hdr0); end
  endtask

  task automatic test_timeout();
    do_reset();
    cyc0(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (15) cyc0(1'b0, 1'b0, 32'h0, 1'b0);
    n_chk++; if (err0 !== 4'h0) begin n_fail++; $display("FAIL tmo_early got=%b exp=0000", err0); end
    cyc0(1'b0, 1'b0, 32'h0, 1'b0);
    n_chk++; if (err0 !== 4'b0100) begin n_fail++; $display("FAIL tmo_err got=%b exp=0100", err0); end
    repeat (5) cyc0(1'b0, 1'b0, 32'h0, 1'b0);
    send_pkt0(32'hC0DE0003, -1, -1, 1'b0);
    n_chk++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL tmo_done got=%b exp=1", done0); end
    n_chk++; if (hdr0 !== 32'hC0DE0003) begin n_fail++; $display("FAIL tmo_hdr got=%h exp=c0de0003", hdr0); end
    n_chk++; if (err0 !== 4'b0100) begin n_fail++; $display("FAIL tmo_sticky got=%b exp=0100", err0); end
  endtask

  task automatic test_overflow();
    do_reset();
    cyc0(1'b1, 1'b0, 32'h0, 1'b0);
    cyc0(1'b1, 1'b0, 32'h0, 1'b0);
    n_chk++; if (err0 !== 4'h0) begin n_fail++; $display("FAIL ovf_early got=%b exp=0000", err0); end
    cyc0(1'b1, 1'b0, 32'h0, 1'b0);
    n_chk++; if (err0 !== 4'b1000) begin n_fail++; $display("FAIL ovf_err got=%b exp=1000", err0); end
    do_reset();
    cyc0(1'b1, 1'b1, 32'h0, 1'b0);        // req and grant together at zero outstanding
    n_chk++;
    if ({busy0, err0} !== 5'b10000) begin
      n_fail++; $display("FAIL cancel_start got=%b/%b exp=1/0000", busy0, err0);
    end
    cyc0(1'b0, 1'b0, 32'hD00D0004, 1'b0);
    for (int b = 0; b < 4; b++) cyc0(1'b0, 1'b0, 32'h11111111 * 32'(b + 1), 1'b0);
    n_chk++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL cancel_done got=%b exp=1", done0); end
    n_chk++; if (hdr0 !== 32'hD00D0004) begin n_fail++; $display("FAIL cancel_hdr got=%h exp=d00d0004", hdr0); end
    n_chk++; if (err0 !== 4'h0) begin n_fail++; $display("FAIL cancel_err got=%b exp=0000", err0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc0(1'b1, 1'b0, 32'h0, 1'b0);
    send_pkt0(32'hE0E00005, -1, -1, 1'b0);
    cyc0(1'b0, 1'b1, 32'h0, 1'b0);        // spurious, sets err[1]
    cyc0(1'b1, 1'b0, 32'h0, 1'b0);
    cyc0(1'b0, 1'b1, 32'h0, 1'b0);
    cyc0(1'b0, 1'b0, 32'hE0E00006, 1'b0);
    cyc0(1'b0, 1'b0, 32'h11111111, 1'b0);
    n_chk++;
    if ({busy0, cnt0, err0} !== {1'b1, 16'd1, 4'b0010}) begin
      n_fail++; $display("FAIL rmid_pre got=%b/%0d/%b exp=1/1/0010", busy0, cnt0, err0);
    end
    rst = 1'b1;
    cyc0(1'b0, 1'b0, 32'h22222222, 1'b0);
    rst = 1'b0;
    n_chk++;
    if ({busy0, done0, hdr0, cnt0, err0} !== '0) begin
      n_fail++;
      $display("FAIL rmid_clear got=%b/%b/%h/%0d/%b exp=all 0", busy0, done0, hdr0, cnt0, err0);
    end
  endtask

  task automatic test_multi_enable();
    do_reset();
    cyc1(2'b11, 2'b00, 64'h0, 64'h0);
    cyc1(2'b00, 2'b01, 64'h0, 64'h0);
    cyc1(2'b00, 2'b10, 64'h0000_0000_AAAA_0001, 64'h0);
    cyc1(2'b00, 2'b00, 64'h0101_0101_0101_0101, 64'h0000_0000_BBBB_0001);
    cyc1(2'b00, 2'b00, 64'h0202_0202_0202_0202, 64'h0303_0303_0303_0303);
    n_chk++; if (done1 !== 2'b01) begin n_fail++; $display("FAIL mc_done0 got=%b exp=01", done1); end
    n_chk++;
    if (hdr1[63:0] !== 64'h0000_0000_AAAA_0001) begin
      n_fail++; $display("FAIL mc_hdr0 got=%h exp=aaaa0001", hdr1[63:0]);
    end
    n_chk++; if (cnt1 !== 32'h0000_0001) begin n_fail++; $display("FAIL mc_cnt_a got=%h exp=00000001", cnt1); end
    cyc1(2'b00, 2'b00, 64'h0, 64'h0404_0404_0404_0404);
    n_chk++; if (done1 !== 2'b10) begin n_fail++; $display("FAIL mc_done1 got=%b exp=10", done1); end
    n_chk++;
    if (hdr1[127:64] !== 64'h0000_0000_BBBB_0001) begin
      n_fail++; $display("FAIL mc_hdr1 got=%h exp=bbbb0001", hdr1[127:64]);
    end
    n_chk++; if (cnt1 !== 32'h0001_0001) begin n_fail++; $display("FAIL mc_cnt_b got=%h exp=00010001", cnt1); end
    n_chk++; if (err1 !== 8'h00) begin n_fail++; $display("FAIL mc_err got=%b exp=0", err1); end

    cyc1(2'b10, 2'b00, 64'h0, 64'h0);
    cyc1(2'b00, 2'b10, 64'h0, 64'h0);
    cyc1(2'b00, 2'b00, 64'h0, 64'h0000_0000_CCCC_0002);
    cyc1(2'b00, 2'b00, 64'h0, 64'h0505_0505_0505_0505);
    n_chk++; if (busy1 !== 2'b10) begin n_fail++; $display("FAIL en_inpay got=%b exp=10", busy1); end
    en1 = 1'b0;
    cyc1(2'b00, 2'b01, 64'h0, 64'h0606_0606_0606_0606);  // grant on ch0 ignored
    n_chk++;
    if ({busy1, done1, err1} !== 12'h0) begin
      n_fail++; $display("FAIL en_drop got=%b/%b/%b exp=00/00/0", busy1, done1, err1);
    end
    en1 = 1'b1;
    cyc1(2'b00, 2'b00, 64'h0, 64'h0);
    n_chk++; if (done1 !== 2'b00) begin n_fail++; $display("FAIL en_nodone got=%b exp=00", done1); end
    n_chk++; if (cnt1 !== 32'h0001_0001) begin n_fail++; $display("FAIL en_cnt_hold got=%h exp=00010001", cnt1); end
    n_chk++;
    if (hdr1[127:64] !== 64'h0000_0000_BBBB_0001) begin
      n_fail++; $display("FAIL en_hdr_hold got=%h exp=bbbb0001", hdr1[127:64]);
    end
    cyc1(2'b10, 2'b00, 64'h0, 64'h0);
    cyc1(2'b00, 2'b10, 64'h0, 64'h0);
    cyc1(2'b00, 2'b00, 64'h0, 64'h0000_0000_DDDD_0003);
    cyc1(2'b00, 2'b00, 64'h0, 64'h0707_0707_0707_0707);
    cyc1(2'b00, 2'b00, 64'h0, 64'h0808_0808_0808_0808);
    n_chk++;
    if ({done1, cnt1} !== {2'b10, 32'h0002_0001}) begin
      n_fail++; $display("FAIL en_recover got=%b/%h exp=10/00020001", done1, cnt1);
    end
    n_chk++;
    if (hdr1[127:64] !== 64'h0000_0000_DDDD_0003) begin
      n_fail++; $display("FAIL en_recover_hdr got=%h exp=dddd0003", hdr1[127:64]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en0 = 1'b1; en1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_spurious();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_multi_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
